// File: rtl/picorv32_pcpi_mul_seq.sv
// PicoRV32 PCPI coprocessor for MUL/MULH/MULHSU/MULHU built on a shared
// 32x16 unsigned multiplier: sign-magnitude operands, one or two partial products.
module picorv32_pcpi_mul_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        mul_req,
    output logic [31:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_gnt,
    input  logic        mul_valid,
    input  logic [47:0] mul_p
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LO      = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_HI      = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_SIGN    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [63:0] acc_r;
    logic [31:0] ua_r;
    logic [31:0] ub_r;
    logic [2:0]  f3_r;
    logic        neg_r;
    logic        abort_r;

    logic        accept_s;
    logic [2:0]  f3_in_s;
    logic        sa_s;
    logic        sb_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic        discard_s;
    logic        hi_zero_s;
    logic        unused_s;

    // Gating with resetn keeps pcpi_wait low while reset is held.
    assign accept_s  = resetn & pcpi_valid
                     & (pcpi_insn[6:0] == 7'b0110011)
                     & (pcpi_insn[31:25] == 7'b0000001)
                     & ~pcpi_insn[14];
    assign f3_in_s   = pcpi_insn[14:12];
    assign sa_s      = (f3_in_s == 3'b001) | (f3_in_s == 3'b010);
    assign sb_s      = (f3_in_s == 3'b001);
    assign neg_a_s   = sa_s & pcpi_rs1[31];
    assign neg_b_s   = sb_s & pcpi_rs2[31];
    assign discard_s = abort_r | ~pcpi_valid;
    assign hi_zero_s = (ub_r[31:16] == 16'd0);
    assign unused_s  = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a dropped pcpi_valid abandons the operation.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_LO;
                else          state_nxt_s = ST_IDLE;
            end
            ST_LO: begin
                if (!pcpi_valid)  state_nxt_s = ST_IDLE;
                else if (mul_gnt) state_nxt_s = ST_WAIT_LO;
                else              state_nxt_s = ST_LO;
            end
            ST_WAIT_LO: begin
                if (!mul_valid)     state_nxt_s = ST_WAIT_LO;
                else if (discard_s) state_nxt_s = ST_IDLE;
                else if (hi_zero_s) state_nxt_s = ST_SIGN;
                else                state_nxt_s = ST_HI;
            end
            ST_HI: begin
                if (!pcpi_valid)  state_nxt_s = ST_IDLE;
                else if (mul_gnt) state_nxt_s = ST_WAIT_HI;
                else              state_nxt_s = ST_HI;
            end
            ST_WAIT_HI: begin
                if (!mul_valid)     state_nxt_s = ST_WAIT_HI;
                else if (discard_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_SIGN;
            end
            ST_SIGN: state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand capture: magnitudes and result sign are fixed at accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f3_r  <= 3'd0;
            neg_r <= 1'b0;
            ua_r  <= 32'd0;
            ub_r  <= 32'd0;
        end else if ((state_r == ST_IDLE) && accept_s) begin
            f3_r  <= f3_in_s;
            neg_r <= neg_a_s ^ neg_b_s;
            ua_r  <= neg_a_s ? neg32(pcpi_rs1) : pcpi_rs1;
            ub_r  <= neg_b_s ? neg32(pcpi_rs2) : pcpi_rs2;
        end
    end

    // Accumulator: low partial, shifted high partial, then sign fix-up.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r <= 64'd0;
        end else begin
            case (state_r)
                ST_WAIT_LO: begin
                    if (mul_valid && !discard_s) acc_r <= {16'd0, mul_p};
                end
                ST_WAIT_HI: begin
                    if (mul_valid && !discard_s) acc_r <= acc_r + {mul_p, 16'd0};
                end
                ST_SIGN: begin
                    if (neg_r) acc_r <= neg64(acc_r);
                end
                default: acc_r <= acc_r;
            endcase
        end
    end

    // Abort flag: remembers a dropped request while a product is in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            abort_r <= 1'b0;
        end else if (state_nxt_s == ST_IDLE) begin
            abort_r <= 1'b0;
        end else if (((state_r == ST_WAIT_LO) || (state_r == ST_WAIT_HI)) && !pcpi_valid) begin
            abort_r <= 1'b1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'd0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        mul_req    = 1'b0;
        mul_a      = 32'd0;
        mul_b      = 16'd0;
        case (state_r)
            ST_IDLE: begin
                pcpi_wait = accept_s;
            end
            ST_LO: begin
                pcpi_wait = 1'b1;
                mul_req   = 1'b1;
                mul_a     = ua_r;
                mul_b     = ub_r[15:0];
            end
            ST_HI: begin
                pcpi_wait = 1'b1;
                mul_req   = 1'b1;
                mul_a     = ua_r;
                mul_b     = ub_r[31:16];
            end
            ST_WAIT_LO, ST_WAIT_HI, ST_SIGN: begin
                pcpi_wait = 1'b1;
            end
            ST_DONE: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                if (f3_r == 3'b000) pcpi_rd = acc_r[31:0];
                else                pcpi_rd = acc_r[63:32];
            end
            default: begin
                pcpi_wait = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_picorv32_pcpi_mul_seq.sv
// Scoreboard bench: stimulus pushes reference results, a monitor checks each
// pcpi_ready pulse; a behavioural 32x16 multiplier answers mul_req.
module tb_picorv32_pcpi_mul_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = 32'd0;
    logic [31:0] pcpi_rs1 = 32'd0;
    logic [31:0] pcpi_rs2 = 32'd0;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        mul_req;
    logic [31:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_gnt = 1'b0;
    logic        mul_valid = 1'b0;
    logic [47:0] mul_p = 48'd0;

    picorv32_pcpi_mul_seq dut (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
        .mul_gnt(mul_gnt), .mul_valid(mul_valid), .mul_p(mul_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        int          lat;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // multiplier model controls
    int          gnt_mode = 0;
    int          stall_cnt = 0;
    int          gnt_cnt = 0;
    bit          spur_en = 1'b0;
    bit          pend = 1'b0;
    logic [47:0] pend_p = 48'd0;
    logic [15:0] last_b = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: full 64-bit product of the extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (f3 == 2'd1 || f3 == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f3 == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (f3 == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Shared multiplier: grant per gnt_mode, product one cycle after grant.
    always @(negedge clk) begin
        if (pend) begin
            mul_valid = 1'b1;
            mul_p     = pend_p;
            pend      = 1'b0;
        end else begin
            mul_valid = spur_en && ($urandom_range(3, 0) == 0);
            mul_p     = {16'($urandom()), $urandom()};
        end
        mul_gnt = 1'b0;
        if (mul_req) begin
            if (stall_cnt > 0) begin
                stall_cnt--;
            end else if (gnt_mode == 0 || $urandom_range(9, 0) < 7) begin
                mul_gnt = 1'b1;
                pend    = 1'b1;
                pend_p  = 48'(mul_a) * 48'(mul_b);
                last_b  = mul_b;
                gnt_cnt++;
            end
        end
    end

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (pcpi_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got rd=%h expected no ready", pcpi_rd);
            end else begin
                e = exp_q.pop_front();
                chk("rd", pcpi_rd, e.rd);
                chk("wr_with_ready", 32'(pcpi_wr), 32'd1);
                if (e.lat >= 0) chk("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end else begin
            chk("rd_zero_idle", pcpi_rd, 32'd0);
            chk("wr_zero_idle", 32'(pcpi_wr), 32'd0);
        end
    end

    task automatic issue(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b);
        pcpi_insn  = {7'b0000001, 5'($urandom()), 5'($urandom()), 1'b0, f3,
                      5'($urandom()), 7'b0110011};
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        #1;
        chk("wait_on_accept", 32'(pcpi_wait), 32'd1);
    endtask

    task automatic run_op(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int stable_n);
        exp_t e;
        bit   got;
        e.rd = ref_mul(f3, a, b);
        e.lat = lat;
        e.t0 = cyc;
        exp_q.push_back(e);
        issue(f3, a, b);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pcpi_ready) begin
                got = 1'b1;
                break;
            end
            chk("wait_busy", 32'(pcpi_wait), 32'd1);
            if (i < stable_n) begin
                chk("stall_req", 32'(mul_req), 32'd1);
                chk("stall_a", mul_a, a);
                chk("stall_b", 32'(mul_b), 32'(b[15:0]));
            end
        end
        chk("ready_seen", 32'(got), 32'd1);
        chk("wait_in_done", 32'(pcpi_wait), 32'd0);
        pcpi_valid = 1'b0;
    endtask

    task automatic chk_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk({name, "_req"}, 32'(mul_req), 32'd0);
            chk({name, "_ready"}, 32'(pcpi_ready), 32'd0);
            chk({name, "_wait"}, 32'(pcpi_wait), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_wr"}, 32'(pcpi_wr), 32'd0);
        chk({name, "_rd"}, pcpi_rd, 32'd0);
        chk({name, "_wait"}, 32'(pcpi_wait), 32'd0);
        chk({name, "_ready"}, 32'(pcpi_ready), 32'd0);
        chk({name, "_req"}, 32'(mul_req), 32'd0);
        chk({name, "_a"}, mul_a, 32'd0);
        chk({name, "_b"}, 32'(mul_b), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int            g0;
        logic [31:0]   spec [5];
        logic [31:0]   ra;
        logic [31:0]   rb;
        spec = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // MUL 7 x -3: two passes, no stall
        g0 = gnt_cnt;
        run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 6, 0);
        chk("mul_grants", 32'(gnt_cnt - g0), 32'd2);
        @(negedge clk);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 6, 0);
        @(negedge clk);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 0);
        @(negedge clk);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 0);
        @(negedge clk);

        // upper half of rs2 zero: single request
        g0 = gnt_cnt;
        run_op(2'd3, 32'h1234_5678, 32'd5, 4, 0);
        chk("single_grant", 32'(gnt_cnt - g0), 32'd1);
        chk("single_b", 32'(last_b), 32'd5);
        @(negedge clk);

        // grant withheld for 10 cycles in LO
        stall_cnt = 10;
        run_op(2'd0, 32'h0000_1234, 32'h0003_0005, 16, 11);
        @(negedge clk);

        // non-multiply instructions are not accepted
        pcpi_insn  = 32'h0200_4033;
        pcpi_valid = 1'b1;
        #1;
        chk("div_no_wait", 32'(pcpi_wait), 32'd0);
        chk_quiet("div", 3);
        pcpi_insn = 32'h0200_0037;
        #1;
        chk("opc_no_wait", 32'(pcpi_wait), 32'd0);
        chk_quiet("opc", 3);
        pcpi_valid = 1'b0;
        @(negedge clk);

        // abort in LO while the grant is stalled
        stall_cnt = 5;
        issue(2'd0, 32'd9, 32'd9);
        @(negedge clk);
        @(negedge clk);
        pcpi_valid = 1'b0;
        chk_quiet("abort_lo", 4);
        stall_cnt = 0;

        // abort in WAIT_LO: product arrives and is dropped
        issue(2'd0, 32'd11, 32'h0001_0003);
        @(negedge clk);
        @(negedge clk);
        pcpi_valid = 1'b0;
        #1;
        chk("abort_wlo_wait", 32'(pcpi_wait), 32'd1);
        chk_quiet("abort_wlo", 8);

        // reset in HI
        issue(2'd0, 32'h0000_0010, 32'h0002_0001);
        repeat (3) @(negedge clk);
        chk("hi_req", 32'(mul_req), 32'd1);
        chk("hi_b", 32'(mul_b), 32'd2);
        resetn = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        pcpi_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk_quiet("post_reset", 6);
        run_op(2'd0, 32'd3, 32'd4, 4, 0);
        @(negedge clk);

        // randomized traffic with random grants and spurious mul_valid
        gnt_mode = 1;
        spur_en  = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(3, 0))
                0:       ra = spec[$urandom_range(4, 0)];
                default: ra = $urandom();
            endcase
            case ($urandom_range(3, 0))
                0:       rb = spec[$urandom_range(4, 0)];
                1:       rb = $urandom() & 32'h0000_FFFF;
                default: rb = $urandom();
            endcase
            run_op(2'($urandom_range(3, 0)), ra, rb, -1, 0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
